match_sequencer: RTL and testbench

Central match-flow controller for the quidditch game. It sequences idle, kickoff, play, post-goal pause and game-over. It owns the match clock and both team scores, and gates the ball and player controllers through play_enable and ball_reset. It sits beside the ball controller, which reports goals, and drives the display path with time, score and winner.

---
 rtl/match_sequencer_if.sv | 43 ++++
 rtl/match_sequencer.sv | 167 ++++++++++++++++
 tb/tb_match_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/match_sequencer_if.sv
// Match sequencer bus: switch and goal inputs plus the
// time, score and winner outputs toward the display path.
interface match_sequencer_if;
  logic       game_on_switch;
  logic       goal_team1;
  logic       goal_team2;
  logic       play_enable;
  logic       ball_reset;
  logic [7:0] time_left;
  logic [3:0] team1_score;
  logic [3:0] team2_score;
  logic [3:0] phase_left;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    input  game_on_switch,
    input  goal_team1,
    input  goal_team2,
    output play_enable,
    output ball_reset,
    output time_left,
    output team1_score,
    output team2_score,
    output phase_left,
    output game_over,
    output winner
  );

  modport slave (
    output game_on_switch,
    output goal_team1,
    output goal_team2,
    input  play_enable,
    input  ball_reset,
    input  time_left,
    input  team1_score,
    input  team2_score,
    input  phase_left,
    input  game_over,
    input  winner
  );
endinterface

// File: rtl/match_sequencer.sv
// Quidditch match-flow controller: kickoff, play, goal pause
// and game over, owning the match clock and both scores.
module match_sequencer #(
  parameter int TICKS_PER_SEC      = 50000000,
  parameter int MATCH_SECONDS      = 180,
  parameter int KICKOFF_SECONDS    = 3,
  parameter int GOAL_PAUSE_SECONDS = 2,
  parameter int MAX_SCORE          = 9
) (
  input  logic               clk,
  input  logic               rst,
  match_sequencer_if.master  bus
);

  localparam int CW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] SMAX = 4'(MAX_SCORE);

  typedef enum logic [2:0] {
    IDLE,
    KICKOFF,
    PLAY,
    GOAL_PAUSE,
    OVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] sec_q, sec_d;
  logic [7:0]    time_q, time_d;
  logic [3:0]    t1_q, t1_d;
  logic [3:0]    t2_q, t2_d;
  logic [3:0]    phase_q, phase_d;
  logic          play_en_q, play_en_d;
  logic          ball_rst_q, ball_rst_d;
  logic          over_q, over_d;
  logic [1:0]    winner_q, winner_d;

  logic sw, cnt_en, tick, g1, g2;

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    time_d     = time_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    phase_d    = phase_q;
    play_en_d  = 1'b0;
    ball_rst_d = 1'b0;
    over_d     = over_q;
    winner_d   = winner_q;

    sw = bus.game_on_switch;
    cnt_en = sw && (state_q == KICKOFF
                 || state_q == PLAY
                 || state_q == GOAL_PAUSE);
    tick = cnt_en && (sec_q == TMAX);
    g1 = sw && bus.goal_team1;
    g2 = sw && bus.goal_team2;

    if (cnt_en) begin
      sec_d = tick ? '0 : sec_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sw) begin
          state_d    = KICKOFF;
          phase_d    = 4'(KICKOFF_SECONDS);
          ball_rst_d = 1'b1;
        end
      end
      KICKOFF: begin
        if (tick) begin
          if (phase_q <= 4'd1) begin
            state_d   = PLAY;
            phase_d   = '0;
            play_en_d = 1'b1;
          end else begin
            phase_d = phase_q - 4'd1;
          end
        end
      end
      PLAY: begin
        if (tick && time_q != '0) begin
          time_d = time_q - 8'd1;
        end
        if (g1 && t1_q < SMAX) t1_d = t1_q + 4'd1;
        if (g2 && t2_q < SMAX) t2_d = t2_q + 4'd1;
        // Game end outranks the goal pause, so no ball_reset then.
        if (t1_d == SMAX || t2_d == SMAX
            || (tick && time_d == '0)) begin
          state_d = OVER;
          over_d  = 1'b1;
          unique case (1'b1)
            t1_d > t2_d: winner_d = 2'b01;
            t2_d > t1_d: winner_d = 2'b10;
            default:     winner_d = 2'b11;
          endcase
        end else if (g1 || g2) begin
          state_d    = GOAL_PAUSE;
          phase_d    = 4'(GOAL_PAUSE_SECONDS);
          ball_rst_d = 1'b1;
        end else begin
          play_en_d = sw;
        end
      end
      GOAL_PAUSE: begin
        if (tick) begin
          if (phase_q <= 4'd1) begin
            state_d   = PLAY;
            phase_d   = '0;
            play_en_d = 1'b1;
          end else begin
            phase_d = phase_q - 4'd1;
          end
        end
      end
      OVER: begin
        over_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      sec_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      time_q     <= 8'(MATCH_SECONDS);
      t1_q       <= '0;
      t2_q       <= '0;
      phase_q    <= '0;
      play_en_q  <= 1'b0;
      ball_rst_q <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      time_q     <= time_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      phase_q    <= phase_d;
      play_en_q  <= play_en_d;
      ball_rst_q <= ball_rst_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
    end
  end

  assign bus.play_enable = play_en_q;
  assign bus.ball_reset  = ball_rst_q;
  assign bus.time_left   = time_q;
  assign bus.team1_score = t1_q;
  assign bus.team2_score = t2_q;
  assign bus.phase_left  = phase_q;
  assign bus.game_over   = over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short game
// parameters and hand-computed expectations.
module tb_match_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  match_sequencer_if bus ();

  match_sequencer #(
    .TICKS_PER_SEC      (4),
    .MATCH_SECONDS      (5),
    .KICKOFF_SECONDS    (2),
    .GOAL_PAUSE_SECONDS (1),
    .MAX_SCORE          (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_time"}, int'(bus.time_left), 5);
    chk({tag, "_t1"}, int'(bus.team1_score), 0);
    chk({tag, "_t2"}, int'(bus.team2_score), 0);
    chk({tag, "_phase"}, int'(bus.phase_left), 0);
    chk({tag, "_pen"}, int'(bus.play_enable), 0);
    chk({tag, "_brst"}, int'(bus.ball_reset), 0);
    chk({tag, "_over"}, int'(bus.game_over), 0);
    chk({tag, "_win"}, int'(bus.winner), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.game_on_switch = 1'b0;
    bus.goal_team1 = 1'b0;
    bus.goal_team2 = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  // Leaves the bench just after the PLAY entry edge.
  task automatic to_play();
    do_reset();
    bus.game_on_switch = 1'b1;
    step(9);
  endtask

  task automatic goal(input logic a, input logic b);
    bus.goal_team1 = a;
    bus.goal_team2 = b;
    step(1);
    bus.goal_team1 = 1'b0;
    bus.goal_team2 = 1'b0;
  endtask

  initial begin
    bus.game_on_switch = 1'b0;
    bus.goal_team1 = 1'b0;
    bus.goal_team2 = 1'b0;

    // Reset and kickoff
    do_reset();
    chk_reset("rst");
    step(1);
    chk("idle_phase", int'(bus.phase_left), 0);
    bus.game_on_switch = 1'b1;
    step(1);
    chk("ko_brst", int'(bus.ball_reset), 1);
    chk("ko_phase", int'(bus.phase_left), 2);
    chk("ko_pen", int'(bus.play_enable), 0);
    step(1);
    chk("ko_brst_off", int'(bus.ball_reset), 0);
    step(3);
    chk("ko_phase1", int'(bus.phase_left), 1);
    step(3);
    chk("ko_pen_late", int'(bus.play_enable), 0);
    step(1);
    chk("play_pen", int'(bus.play_enable), 1);
    chk("play_time", int'(bus.time_left), 5);
    chk("play_phase", int'(bus.phase_left), 0);

    // Free-running play to time-out
    step(4);
    chk("run_time4", int'(bus.time_left), 4);
    step(15);
    chk("run_time1", int'(bus.time_left), 1);
    chk("run_over0", int'(bus.game_over), 0);
    step(1);
    chk("run_over", int'(bus.game_over), 1);
    chk("run_win", int'(bus.winner), 3);
    chk("run_time0", int'(bus.time_left), 0);
    chk("run_pen", int'(bus.play_enable), 0);
    bus.game_on_switch = 1'b0;
    step(3);
    chk("run_hold", int'(bus.game_over), 1);

    // Single goal and pause
    to_play();
    step(2);
    goal(1'b1, 1'b0);
    chk("g1_score", int'(bus.team1_score), 1);
    chk("g1_brst", int'(bus.ball_reset), 1);
    chk("g1_pen", int'(bus.play_enable), 0);
    chk("g1_phase", int'(bus.phase_left), 1);
    step(3);
    chk("g1_pen3", int'(bus.play_enable), 0);
    chk("g1_time", int'(bus.time_left), 5);
    step(1);
    chk("g1_resume", int'(bus.play_enable), 1);
    chk("g1_phase0", int'(bus.phase_left), 0);
    step(4);
    chk("g1_time4", int'(bus.time_left), 4);

    // Simultaneous goals, then goal ignored during pause
    to_play();
    goal(1'b1, 1'b1);
    chk("gg_t1", int'(bus.team1_score), 1);
    chk("gg_t2", int'(bus.team2_score), 1);
    chk("gg_brst", int'(bus.ball_reset), 1);
    step(1);
    goal(1'b0, 1'b1);
    chk("gg_ign_t2", int'(bus.team2_score), 1);
    chk("gg_ign_brst", int'(bus.ball_reset), 0);
    step(1);
    chk("gg_pen", int'(bus.play_enable), 0);
    step(1);
    chk("gg_resume", int'(bus.play_enable), 1);
    chk("gg_t1_end", int'(bus.team1_score), 1);

    // Mercy rule
    to_play();
    goal(1'b0, 1'b1);
    chk("m_t2_1", int'(bus.team2_score), 1);
    step(4);
    chk("m_resume", int'(bus.play_enable), 1);
    goal(1'b0, 1'b1);
    chk("m_t2_2", int'(bus.team2_score), 2);
    step(4);
    goal(1'b0, 1'b1);
    chk("m_t2_3", int'(bus.team2_score), 3);
    chk("m_over", int'(bus.game_over), 1);
    chk("m_win", int'(bus.winner), 2);
    chk("m_brst", int'(bus.ball_reset), 0);
    chk("m_pen", int'(bus.play_enable), 0);
    goal(1'b0, 1'b1);
    chk("m_sat", int'(bus.team2_score), 3);

    // Goal on the final tick
    to_play();
    step(19);
    chk("ft_time1", int'(bus.time_left), 1);
    goal(1'b1, 1'b0);
    chk("ft_t1", int'(bus.team1_score), 1);
    chk("ft_over", int'(bus.game_over), 1);
    chk("ft_win", int'(bus.winner), 1);
    chk("ft_brst", int'(bus.ball_reset), 0);
    chk("ft_time0", int'(bus.time_left), 0);

    // Switch pause mid-play
    to_play();
    step(2);
    bus.game_on_switch = 1'b0;
    step(1);
    chk("sp_pen", int'(bus.play_enable), 0);
    step(9);
    chk("sp_time", int'(bus.time_left), 5);
    chk("sp_pen9", int'(bus.play_enable), 0);
    bus.game_on_switch = 1'b1;
    step(1);
    chk("sp_pen_on", int'(bus.play_enable), 1);
    chk("sp_time_b", int'(bus.time_left), 5);
    step(1);
    chk("sp_time4", int'(bus.time_left), 4);

    // Reset in goal pause
    goal(1'b1, 1'b0);
    step(1);
    chk("rp_phase", int'(bus.phase_left), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset("rp");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
